osc_lock_ctrl: RTL

//  Digital frequency-lock controller for the N-stage injection-locked ring oscillator.
//  - Runs a two-phase SAR search: delay_con_msb first, then delay_con_lsb.
//    The search drives the measured oscillator count per window to target_cnt.
//  - Then enables edge injection and, optionally, tracks drift in LSB steps.
//  - Sits in the ref_clk domain, beside the oscillator core and its varactor banks.
//  - Reads an oscillator edge count that is gray-decoded and synchronized outside this block.

---
 rtl/osc_lock_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/osc_lock_ctrl.sv
// Frequency-lock controller for the injection-locked ring oscillator: two-phase SAR
// search over the coarse/fine varactor codes, a verify measurement, then optional LSB tracking.
module osc_lock_ctrl #(
    parameter int MSB_W        = 8,
    parameter int LSB_W        = 5,
    parameter int CNT_W        = 16,
    parameter int WIN_CYC      = 256,
    parameter int SETTLE_CYC   = 16,
    parameter int TOL          = 2,
    parameter int TRACK_PERIOD = 4096
) (
    input  logic             ref_clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             abort,
    input  logic             track_en,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [CNT_W-1:0] osc_cnt,
    output logic             glob_en,
    output logic             inj_en,
    output logic [MSB_W-1:0] delay_con_msb,
    output logic [LSB_W-1:0] delay_con_lsb,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             busy,
    output logic             locked,
    output logic             fail
);

    // Control contract: start is a one-cycle request accepted only while the FSM sits
    // in IDLE, LOCKED or FAIL; busy rises the cycle after acceptance and falls when
    // locked/fail is raised or abort is seen. abort is a level that overrides everything.

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_SNAP, ST_WINDOW, ST_DECIDE, ST_LOCKED, ST_TRACK, ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        PH_MSB, PH_LSB, PH_VERIFY, PH_TRACK
    } phase_t;

    localparam int BIT_W   = $clog2((MSB_W > LSB_W) ? MSB_W : LSB_W);
    localparam int TMR_MAX = (TRACK_PERIOD > WIN_CYC) ?
                             ((TRACK_PERIOD > SETTLE_CYC) ? TRACK_PERIOD : SETTLE_CYC) :
                             ((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'(WIN_CYC - 1);
    localparam logic [TMR_W-1:0]  TRK_LAST    = TMR_W'(TRACK_PERIOD - 1);
    localparam logic [BIT_W-1:0]  MSB_TOP     = BIT_W'(MSB_W - 1);
    localparam logic [BIT_W-1:0]  LSB_TOP     = BIT_W'(LSB_W - 1);
    localparam logic [MSB_W-1:0]  MSB_INIT    = {1'b1, {(MSB_W-1){1'b0}}};
    localparam logic [LSB_W-1:0]  LSB_INIT    = {1'b1, {(LSB_W-1){1'b0}}};
    localparam logic [LSB_W-1:0]  LSB_MAX     = '1;
    localparam logic [LSB_W-1:0]  LSB_MIN     = '0;
    localparam logic signed [CNT_W:0] TOL_P   = (CNT_W+1)'(TOL);
    localparam logic signed [CNT_W:0] TOL_N   = (CNT_W+1)'(-TOL);

    state_t             state, state_nxt;
    phase_t             phase, phase_nxt;
    logic [BIT_W-1:0]   bit_idx, bit_nxt, bit_dec;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [CNT_W-1:0]   c0, c0_nxt, c1, c1_nxt;
    logic [MSB_W-1:0]   msb_nxt;
    logic [LSB_W-1:0]   lsb_nxt;
    logic [CNT_W-1:0]   meas_nxt;
    logic               glob_nxt, inj_nxt, busy_nxt, locked_nxt, fail_nxt;

    logic [CNT_W-1:0]   meas_new;
    logic signed [CNT_W:0] diff;
    logic               sar_keep, in_tol, too_fast, too_slow;

    // Modular subtraction keeps the window count correct across osc_cnt wrap.
    assign meas_new = c1 - c0;
    assign diff     = $signed({1'b0, meas_new}) - $signed({1'b0, target_cnt});
    assign sar_keep = meas_new > target_cnt;
    assign in_tol   = (diff <= TOL_P) && (diff >= TOL_N);
    assign too_fast = diff > TOL_P;
    assign too_slow = diff < TOL_N;
    assign bit_dec  = bit_idx - 1'b1;

    always_ff @(posedge ref_clk) begin
        if (!rstb) begin
            state         <= ST_IDLE;
            phase         <= PH_MSB;
            bit_idx       <= '0;
            tmr           <= '0;
            c0            <= '0;
            c1            <= '0;
            delay_con_msb <= '0;
            delay_con_lsb <= '0;
            meas_cnt      <= '0;
            glob_en       <= 1'b0;
            inj_en        <= 1'b0;
            busy          <= 1'b0;
            locked        <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            bit_idx       <= bit_nxt;
            tmr           <= tmr_nxt;
            c0            <= c0_nxt;
            c1            <= c1_nxt;
            delay_con_msb <= msb_nxt;
            delay_con_lsb <= lsb_nxt;
            meas_cnt      <= meas_nxt;
            glob_en       <= glob_nxt;
            inj_en        <= inj_nxt;
            busy          <= busy_nxt;
            locked        <= locked_nxt;
            fail          <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        bit_nxt    = bit_idx;
        tmr_nxt    = tmr;
        c0_nxt     = c0;
        c1_nxt     = c1;
        msb_nxt    = delay_con_msb;
        lsb_nxt    = delay_con_lsb;
        meas_nxt   = meas_cnt;
        glob_nxt   = glob_en;
        inj_nxt    = inj_en;
        busy_nxt   = busy;
        locked_nxt = locked;
        fail_nxt   = fail;

        case (state)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (start) begin
                    msb_nxt    = MSB_INIT;
                    lsb_nxt    = '0;
                    phase_nxt  = PH_MSB;
                    bit_nxt    = MSB_TOP;
                    tmr_nxt    = '0;
                    glob_nxt   = 1'b1;
                    inj_nxt    = 1'b0;
                    busy_nxt   = 1'b1;
                    locked_nxt = 1'b0;
                    fail_nxt   = 1'b0;
                    state_nxt  = ST_SETTLE;
                end else if (state == ST_LOCKED) begin
                    if (!track_en) begin
                        tmr_nxt = '0;
                    end else if (tmr == TRK_LAST) begin
                        tmr_nxt   = '0;
                        phase_nxt = PH_TRACK;
                        state_nxt = ST_SETTLE;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr == SETTLE_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = ST_SNAP;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            ST_SNAP: begin
                c0_nxt    = osc_cnt;
                tmr_nxt   = '0;
                state_nxt = ST_WINDOW;
            end
            ST_WINDOW: begin
                if (tmr == WIN_LAST) begin
                    c1_nxt    = osc_cnt;
                    tmr_nxt   = '0;
                    state_nxt = (phase == PH_TRACK) ? ST_TRACK : ST_DECIDE;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            ST_DECIDE: begin
                meas_nxt  = meas_new;
                state_nxt = ST_SETTLE;
                case (phase)
                    PH_MSB: begin
                        // Too fast means more capacitance is needed, so the trial bit stays.
                        if (!sar_keep) msb_nxt[bit_idx] = 1'b0;
                        if (bit_idx != '0) begin
                            bit_nxt          = bit_dec;
                            msb_nxt[bit_dec] = 1'b1;
                        end else begin
                            phase_nxt = PH_LSB;
                            bit_nxt   = LSB_TOP;
                            lsb_nxt   = LSB_INIT;
                        end
                    end
                    PH_LSB: begin
                        if (!sar_keep) lsb_nxt[bit_idx] = 1'b0;
                        if (bit_idx != '0) begin
                            bit_nxt          = bit_dec;
                            lsb_nxt[bit_dec] = 1'b1;
                        end else begin
                            phase_nxt = PH_VERIFY;
                        end
                    end
                    default: begin
                        busy_nxt = 1'b0;
                        if (in_tol) begin
                            locked_nxt = 1'b1;
                            inj_nxt    = 1'b1;
                            tmr_nxt    = '0;
                            state_nxt  = ST_LOCKED;
                        end else begin
                            fail_nxt  = 1'b1;
                            state_nxt = ST_FAIL;
                        end
                    end
                endcase
            end
            ST_TRACK: begin
                meas_nxt  = meas_new;
                tmr_nxt   = '0;
                state_nxt = ST_LOCKED;
                // A step past either end of the fine range means lock can no longer be held.
                if ((too_fast && delay_con_lsb == LSB_MAX) ||
                    (too_slow && delay_con_lsb == LSB_MIN)) begin
                    locked_nxt = 1'b0;
                    inj_nxt    = 1'b0;
                    fail_nxt   = 1'b1;
                    state_nxt  = ST_FAIL;
                end else if (too_fast) begin
                    lsb_nxt = delay_con_lsb + 1'b1;
                end else if (too_slow) begin
                    lsb_nxt = delay_con_lsb - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_nxt  = ST_IDLE;
            phase_nxt  = phase;
            bit_nxt    = bit_idx;
            tmr_nxt    = '0;
            c0_nxt     = c0;
            c1_nxt     = c1;
            msb_nxt    = delay_con_msb;
            lsb_nxt    = delay_con_lsb;
            meas_nxt   = meas_cnt;
            fail_nxt   = fail;
            glob_nxt   = 1'b0;
            inj_nxt    = 1'b0;
            busy_nxt   = 1'b0;
            locked_nxt = 1'b0;
        end
    end

endmodule
